lbp_hist: RTL

LBP_HIST -- requirements
Module: lbp_hist

---
 rtl/lbp_hist_pkg.sv | 22 ++
 rtl/lbp_hist_mem.sv | 72 +++++++
 rtl/lbp_hist.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lbp_hist_pkg.sv
// lbp_hist_pkg -- shared constants and FSM encoding for the LBP histogram block.
//   LBP_NBIN      : number of histogram bins (one per 8-bit LBP code)
//   LBP_CW        : bin counter width
//   LBP_CODE_W    : width of an LBP code / bin index
//   LBP_DRAIN_LEN : cycles spent in DRAIN letting the accumulate pipeline empty
//   state_e       : controller state encoding (also visible on dbg_state)
package lbp_hist_pkg;

  localparam int LBP_NBIN      = 256;
  localparam int LBP_CW        = 14;
  localparam int LBP_CODE_W    = 8;
  localparam int LBP_DRAIN_LEN = 2;

  typedef enum logic [2:0] {
    ST_ACC   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_FETCH = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/lbp_hist_mem.sv
// lbp_hist_mem -- NBIN x CW bin storage with per-entry touched flags.
//   clk     : rising-edge clock
//   clear   : synchronous clear; drops every touched flag in one cycle and
//             blocks any write in the same cycle
//   rd_en   : capture bin[rd_addr] into rd_data at the next edge
//   rd_addr : read index
//   rd_data : registered read data; holds while rd_en is low; an untouched
//             entry reads as 0
//   wr_en   : write wr_data into bin[wr_addr] and mark it touched
//   wr_addr : write index
//   wr_data : write data
// A read and a write to the same entry on one edge return the old contents;
// the caller forwards around that case.
module lbp_hist_mem
  import lbp_hist_pkg::*;
#(
  parameter int NBIN = LBP_NBIN,
  parameter int CW   = LBP_CW,
  parameter int AW   = $clog2(NBIN)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data
);

  logic [CW-1:0]   mem_q [NBIN];
  logic [NBIN-1:0] touched_q;
  logic [NBIN-1:0] touched_d;
  logic [CW-1:0]   rd_data_q;
  logic [CW-1:0]   rd_data_d;

  always_comb begin
    touched_d = touched_q;
    if (wr_en) begin
      touched_d[wr_addr] = 1'b1;
    end
  end

  // Stale contents of untouched entries are masked here, which is what makes
  // the clear a single-cycle operation.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = touched_q[rd_addr] ? mem_q[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      touched_q <= '0;
      rd_data_q <= '0;
    end else begin
      touched_q <= touched_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array has no reset; validity lives in touched_q.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lbp_hist.sv
// lbp_hist -- accumulates a histogram of 8-bit LBP codes over one frame, then
// streams the bins out in index order.
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset; clears all bins in one cycle
//   lbp_valid  : one LBP code present this cycle (honoured only in ACC)
//   lbp_addr   : pixel address of the code; informational, not used
//   lbp_data   : LBP code, used as bin index
//   finish     : frame complete (level); ends accumulation
//   hist_valid : hist_bin/hist_count hold a bin for the consumer
//   hist_ready : consumer accepts the bin
//   hist_bin   : bin index being presented
//   hist_count : count of that bin (0 when hist_valid is low)
//   hist_total : saturating count of all accepted codes
//   hist_done  : every bin has been delivered; held until reset
//   dbg_state  : current controller state
//
// Output handshake: a bin transfers on a rising edge where hist_valid and
// hist_ready are both 1. While hist_valid is 1 and the bin has not
// transferred, hist_bin and hist_count do not change, and hist_valid does
// not drop.
module lbp_hist
  import lbp_hist_pkg::*;
#(
  parameter int NBIN = LBP_NBIN,
  parameter int CW   = LBP_CW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lbp_valid,
  input  logic [13:0]           lbp_addr,
  input  logic [LBP_CODE_W-1:0] lbp_data,
  input  logic                  finish,
  output logic                  hist_valid,
  input  logic                  hist_ready,
  output logic [LBP_CODE_W-1:0] hist_bin,
  output logic [CW-1:0]         hist_count,
  output logic [CW-1:0]         hist_total,
  output logic                  hist_done,
  output state_e                dbg_state
);

  localparam logic [CW-1:0]         CNT_MAX   = '1;
  localparam logic [LBP_CODE_W-1:0] PTR_LAST  = LBP_CODE_W'(NBIN - 1);
  localparam logic [1:0]            DRAIN_END = 2'(LBP_DRAIN_LEN - 1);

  state_e                state_q, state_d;
  logic [LBP_CODE_W-1:0] ptr_q, ptr_d;
  logic [1:0]            drain_q, drain_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [LBP_CODE_W-1:0] s1_code_q, s1_code_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [LBP_CODE_W-1:0] s2_code_q, s2_code_d;
  logic                  fwd_q, fwd_d;
  logic [CW-1:0]         fwd_val_q, fwd_val_d;
  logic [CW-1:0]         total_q, total_d;

  logic                  acc_fire;
  logic [CW-1:0]         s2_base;
  logic [CW-1:0]         s2_sum;

  logic                  mem_rd_en;
  logic [LBP_CODE_W-1:0] mem_rd_addr;
  logic [CW-1:0]         mem_rd_data;

  logic                  unused_addr;
  assign unused_addr = ^lbp_addr;

  // ------------------------------------------------------------------
  // Accumulate pipeline.
  // Stage 1 holds the code and issues the bin read; stage 2 gets the read
  // data, adds one (saturating) and writes back at the end of its cycle.
  // When stage 1 holds the same code as stage 2, the read issued by stage 1
  // lands on the same edge as stage 2's write and returns the old value, so
  // stage 2's result is captured in fwd_val_q and used instead.
  // ------------------------------------------------------------------
  assign acc_fire = (state_q == ST_ACC) && lbp_valid;

  always_comb begin
    s2_base = fwd_q ? fwd_val_q : mem_rd_data;
    s2_sum  = (s2_base == CNT_MAX) ? CNT_MAX : s2_base + 1'b1;
  end

  always_comb begin
    s1_valid_d = acc_fire;
    s1_code_d  = acc_fire ? lbp_data : s1_code_q;
    s2_valid_d = s1_valid_q;
    s2_code_d  = s1_code_q;
    fwd_d      = s1_valid_q && s2_valid_q && (s1_code_q == s2_code_q);
    fwd_val_d  = s2_sum;
    total_d    = total_q;
    if (acc_fire && (total_q != CNT_MAX)) begin
      total_d = total_q + 1'b1;
    end
  end

  // The read port is shared: FETCH only happens after DRAIN has emptied the
  // pipeline, so stage 1 is never valid at the same time.
  always_comb begin
    mem_rd_en   = s1_valid_q || (state_q == ST_FETCH);
    mem_rd_addr = (state_q == ST_FETCH) ? ptr_q : s1_code_q;
  end

  lbp_hist_mem #(
    .NBIN (NBIN),
    .CW   (CW),
    .AW   (LBP_CODE_W)
  ) u_mem (
    .clk     (clk),
    .clear   (reset),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data),
    .wr_en   (s2_valid_q),
    .wr_addr (s2_code_q),
    .wr_data (s2_sum)
  );

  // ------------------------------------------------------------------
  // Controller: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drain_d = drain_q;
    case (state_q)
      ST_ACC: begin
        if (finish) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_END) begin
          state_d = ST_FETCH;
          ptr_d   = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_FETCH: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (hist_ready) begin
          if (ptr_q == PTR_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACC;
      ptr_q      <= '0;
      drain_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      fwd_q      <= 1'b0;
      fwd_val_q  <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      drain_q    <= drain_d;
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s2_valid_q <= s2_valid_d;
      s2_code_q  <= s2_code_d;
      fwd_q      <= fwd_d;
      fwd_val_q  <= fwd_val_d;
      total_q    <= total_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs. The memory read register holds the fetched bin for the whole
  // OUT state because nothing else reads the memory after accumulation.
  // ------------------------------------------------------------------
  always_comb begin
    hist_valid = (state_q == ST_OUT);
    hist_done  = (state_q == ST_DONE);
    hist_bin   = ptr_q;
    hist_count = hist_valid ? mem_rd_data : '0;
    hist_total = total_q;
    dbg_state  = state_q;
  end

endmodule
